// File: rtl/crc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : crc_pkg
// Description : FSM state encoding and default CRC polynomial/seed constants
//               shared by the serial CRC engine and its LFSR step function.
// Revision    : 1.0 - initial release
// ============================================================================
package crc_pkg;

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_CALC  = 2'd1;
  localparam logic [1:0] c_SHIFT = 2'd2;

  // Tap masks exclude the implicit top term, which always receives feedback.
  localparam logic [6:0]  c_CRC8_TAPS  = 7'b1000100;
  localparam logic [7:0]  c_CRC8_SEED  = 8'hD8;
  localparam logic [14:0] c_CRC16_TAPS = 15'h0408;
  localparam logic [15:0] c_CRC16_SEED = 16'hFFFF;
  localparam logic [30:0] c_CRC32_TAPS = 31'h6DB88320;
  localparam logic [31:0] c_CRC32_SEED = 32'hFFFFFFFF;

endpackage
`default_nettype wire

// File: rtl/crc_lfsr_step.sv
`default_nettype none
// ============================================================================
// Module      : crc_lfsr_step
// Description : Combinational one-bit Galois LFSR step (right-shifting form).
// Revision    : 1.0 - initial release
// ============================================================================
module crc_lfsr_step
  import crc_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-2:0] TAPS  = c_CRC8_TAPS
) (
  input  logic [WIDTH-1:0] cur,
  input  logic             din,
  output logic [WIDTH-1:0] nxt
);

  logic w_fb;

  assign w_fb           = cur[0] ^ din;
  assign nxt[WIDTH-1]   = w_fb;

  for (genvar i = 0; i < WIDTH - 1; i++) begin : g_stage
    assign nxt[i] = cur[i+1] ^ (TAPS[i] & w_fb);
  end

endmodule
`default_nettype wire

// File: rtl/crc_serial_engine.sv
`default_nettype none
// ============================================================================
// Module      : crc_serial_engine
// Description : Bit-serial CRC engine with framed input, residue-check mode
//               and a back-pressured LSB-first serial CRC output.
// Revision    : 1.0 - initial release
// ============================================================================
module crc_serial_engine
  import crc_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-2:0] TAPS  = c_CRC8_TAPS,
  parameter logic [WIDTH-1:0] SEED  = c_CRC8_SEED
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             data,
  input  logic             data_valid,
  input  logic             data_last,
  input  logic             check_mode,
  input  logic             out_ready,
  output logic             crc,
  output logic             crc_valid,
  output logic [WIDTH-1:0] crc_word,
  output logic             crc_ok,
  output logic             done,
  output logic             busy
);

  localparam int                 c_CNT_W = $clog2(WIDTH + 1);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

  logic [1:0]         r_state;
  logic [WIDTH-1:0]   r_reg;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_mode;
  logic               r_crc_valid;
  logic               r_done;
  logic               r_busy;
  logic               r_crc_ok;
  logic [WIDTH-1:0]   r_crc_word;
  logic [WIDTH-1:0]   w_next;

  crc_lfsr_step #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_step (
    .cur (r_reg),
    .din (data),
    .nxt (w_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= c_IDLE;
      r_reg       <= SEED;
      r_cnt       <= '0;
      r_mode      <= 1'b0;
      r_crc_valid <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_crc_ok    <= 1'b0;
      r_crc_word  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (start) begin
            r_reg      <= SEED;
            r_mode     <= check_mode;
            r_crc_ok   <= 1'b0;
            r_crc_word <= '0;
            r_state    <= c_CALC;
            r_busy     <= 1'b1;
          end
        end
        c_CALC: begin
          if (data_valid) begin
            r_reg <= w_next;
            if (data_last) begin
              r_crc_word <= w_next;
              if (r_mode) begin
                // A frame carrying its own CRC leaves a zero residue.
                r_crc_ok <= (w_next == '0);
                r_done   <= 1'b1;
                r_state  <= c_IDLE;
                r_busy   <= 1'b0;
              end else begin
                r_cnt       <= '0;
                r_crc_valid <= 1'b1;
                r_state     <= c_SHIFT;
              end
            end
          end
        end
        c_SHIFT: begin
          if (out_ready) begin
            r_reg <= r_reg >> 1;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == c_LAST) begin
              r_crc_valid <= 1'b0;
              r_done      <= 1'b1;
              r_state     <= c_IDLE;
              r_busy      <= 1'b0;
            end
          end
        end
        default: begin
          r_state     <= c_IDLE;
          r_busy      <= 1'b0;
          r_crc_valid <= 1'b0;
        end
      endcase
    end
  end

  assign crc       = r_crc_valid & r_reg[0];
  assign crc_valid = r_crc_valid;
  assign crc_word  = r_crc_word;
  assign crc_ok    = r_crc_ok;
  assign done      = r_done;
  assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_crc_serial_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_crc_serial_engine
// Description : Self-checking bench for the 8-bit default and 16-bit CCITT
//               instances against a bitwise reflected-CRC reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_crc_serial_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Index 0 drives the 8-bit instance, index 1 the 16-bit instance.
  logic [1:0]  start_v, data_v, dv_v, dl_v, cm_v, ordy_v;
  logic [1:0]  crc_v, cvalid_v, ok_v, done_v, busy_v;
  logic [7:0]  word8;
  logic [15:0] word16;

  int tests = 0;
  int fails = 0;
  int done_cnt0 = 0;
  int done_cnt1 = 0;

  crc_serial_engine u_dut8 (
    .clk(clk), .rst(rst), .start(start_v[0]), .data(data_v[0]),
    .data_valid(dv_v[0]), .data_last(dl_v[0]), .check_mode(cm_v[0]),
    .out_ready(ordy_v[0]), .crc(crc_v[0]), .crc_valid(cvalid_v[0]),
    .crc_word(word8), .crc_ok(ok_v[0]), .done(done_v[0]), .busy(busy_v[0])
  );

  crc_serial_engine #(.WIDTH(16), .TAPS(15'h0408), .SEED(16'hFFFF)) u_dut16 (
    .clk(clk), .rst(rst), .start(start_v[1]), .data(data_v[1]),
    .data_valid(dv_v[1]), .data_last(dl_v[1]), .check_mode(cm_v[1]),
    .out_ready(ordy_v[1]), .crc(crc_v[1]), .crc_valid(cvalid_v[1]),
    .crc_word(word16), .crc_ok(ok_v[1]), .done(done_v[1]), .busy(busy_v[1])
  );

  always @(negedge clk) begin
    if (done_v[0] === 1'b1) done_cnt0++;
    if (done_v[1] === 1'b1) done_cnt1++;
  end

  // Reflected CRC: poly includes the top term ({1, TAPS}).
  function automatic logic [31:0] model_crc(input logic [31:0] poly, input logic [31:0] seed,
                                            input int n, input logic [63:0] bits);
    logic [31:0] r;
    r = seed;
    for (int i = 0; i < n; i++) begin
      if (r[0] ^ bits[i]) r = (r >> 1) ^ poly;
      else                r = r >> 1;
    end
    return r;
  endfunction

  function automatic logic [31:0] word_of(input int sel);
    return (sel == 0) ? {24'b0, word8} : {16'b0, word16};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int sel, input bit mode, input int n, input logic [63:0] bits,
                            input bit gaps, input bit start_mid);
    start_v[sel] = 1'b1;
    cm_v[sel]    = mode;
    tick();
    start_v[sel] = 1'b0;
    cm_v[sel]    = 1'b0;
    for (int i = 0; i < n; i++) begin
      while (gaps && $urandom_range(0, 2) == 0) begin
        dv_v[sel]    = 1'b0;
        dl_v[sel]    = 1'($urandom_range(0, 1));
        data_v[sel]  = 1'($urandom_range(0, 1));
        start_v[sel] = start_mid;
        tick();
      end
      dv_v[sel]    = 1'b1;
      data_v[sel]  = bits[i];
      dl_v[sel]    = (i == n - 1);
      start_v[sel] = start_mid;
      tick();
    end
    dv_v[sel]    = 1'b0;
    dl_v[sel]    = 1'b0;
    start_v[sel] = 1'b0;
  endtask

  task automatic collect(input int sel, input int w, input bit tog, input bit start_mid,
                         output logic [31:0] sbits, output bit stable);
    int  k;
    int  cyc;
    bit  prev_hold;
    logic prev_crc;
    k = 0; cyc = 0; prev_hold = 0; prev_crc = 1'b0;
    sbits = '0; stable = 1;
    while (k < w && cyc < 200) begin
      ordy_v[sel] = tog ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
      if (prev_hold && crc_v[sel] !== prev_crc) stable = 0;
      if (cvalid_v[sel] === 1'b1 && ordy_v[sel]) begin
        sbits[k] = crc_v[sel];
        k++;
      end
      prev_hold    = (cvalid_v[sel] === 1'b1) && !ordy_v[sel];
      prev_crc     = crc_v[sel];
      start_v[sel] = start_mid && (cyc == 1);
      tick();
      cyc++;
    end
    ordy_v[sel]  = 1'b0;
    start_v[sel] = 1'b0;
    tests++;
    if (k < w) begin
      fails++;
      $display("FAIL collect_timeout sel=%0d got %0d bits, required %0d", sel, k, w);
    end
  endtask

  task automatic test_reset;
    tests++;
    if ({crc_v[0], cvalid_v[0], ok_v[0], done_v[0], busy_v[0], word8} !== 13'b0) begin
      fails++;
      $display("FAIL reset8 outputs=%b required all zero",
               {crc_v[0], cvalid_v[0], ok_v[0], done_v[0], busy_v[0], word8});
    end
    tests++;
    if ({crc_v[1], cvalid_v[1], ok_v[1], done_v[1], busy_v[1], word16} !== 21'b0) begin
      fails++;
      $display("FAIL reset16 outputs=%b required all zero",
               {crc_v[1], cvalid_v[1], ok_v[1], done_v[1], busy_v[1], word16});
    end
  endtask

  task automatic test_gen_single(input logic d, input logic [7:0] exp);
    logic [31:0] sb;
    bit          st;
    int          d0;
    send_frame(0, 1'b0, 1, {63'b0, d}, 1'b0, 1'b0);
    tests++;
    if (cvalid_v[0] !== 1'b1 || busy_v[0] !== 1'b1) begin
      fails++;
      $display("FAIL gen_latency d=%0d crc_valid=%b busy=%b required 1 1", d, cvalid_v[0], busy_v[0]);
    end
    d0 = done_cnt0;
    collect(0, 8, 1'b0, 1'b0, sb, st);
    tests++;
    if (sb[7:0] !== exp) begin
      fails++;
      $display("FAIL gen_serial d=%0d got %h required %h", d, sb[7:0], exp);
    end
    tests++;
    if (done_v[0] !== 1'b1 || cvalid_v[0] !== 1'b0 || busy_v[0] !== 1'b0) begin
      fails++;
      $display("FAIL gen_done d=%0d done=%b crc_valid=%b busy=%b required 1 0 0",
               d, done_v[0], cvalid_v[0], busy_v[0]);
    end
    tests++;
    if (word8 !== exp) begin
      fails++;
      $display("FAIL gen_word d=%0d got %h required %h", d, word8, exp);
    end
    tick();
    tests++;
    if (done_v[0] !== 1'b0 || done_cnt0 - d0 != 1 || word8 !== exp) begin
      fails++;
      $display("FAIL gen_pulse d=%0d done=%b pulses=%0d word=%h required 0 1 %h",
               d, done_v[0], done_cnt0 - d0, word8, exp);
    end
  endtask

  task automatic test_check_mode;
    logic [63:0] bits;
    logic [63:0] b;
    logic [31:0] exp;
    int          idx;
    bits = {55'b0, 8'h6C, 1'b0};
    send_frame(0, 1'b1, 9, bits, 1'b0, 1'b0);
    tests++;
    if (done_v[0] !== 1'b1 || ok_v[0] !== 1'b1 || word8 !== 8'h00) begin
      fails++;
      $display("FAIL check_good done=%b ok=%b word=%h required 1 1 00", done_v[0], ok_v[0], word8);
    end
    tick();
    tests++;
    if (ok_v[0] !== 1'b1 || done_v[0] !== 1'b0) begin
      fails++;
      $display("FAIL check_hold ok=%b done=%b required 1 0", ok_v[0], done_v[0]);
    end
    for (int t = 0; t < 4; t++) begin
      idx = $urandom_range(0, 8);
      b = bits;
      b[idx] = ~b[idx];
      exp = model_crc(32'hC4, 32'hD8, 9, b);
      send_frame(0, 1'b1, 9, b, 1'b1, 1'b0);
      tests++;
      if (ok_v[0] !== 1'b0 || word8 !== exp[7:0]) begin
        fails++;
        $display("FAIL check_flip idx=%0d ok=%b word=%h required 0 %h", idx, ok_v[0], word8, exp[7:0]);
      end
      tick();
    end
  endtask

  task automatic test_backpressure(input bit start_mid);
    logic [63:0] bits;
    logic [31:0] exp;
    logic [31:0] sb;
    bit          st;
    int          n;
    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(1, 40);
      bits = {$urandom, $urandom};
      exp = model_crc(32'hC4, 32'hD8, n, bits);
      send_frame(0, 1'b0, n, bits, 1'b1, start_mid);
      collect(0, 8, 1'b1, start_mid, sb, st);
      tests++;
      if (sb[7:0] !== exp[7:0] || word8 !== exp[7:0]) begin
        fails++;
        $display("FAIL bp_frame start_mid=%0d n=%0d serial=%h word=%h required %h",
                 start_mid, n, sb[7:0], word8, exp[7:0]);
      end
      tests++;
      if (!st) begin
        fails++;
        $display("FAIL bp_stable crc changed while out_ready=0, required stable");
      end
      tick();
    end
  endtask

  task automatic test_reset_mid;
    int d0;
    send_frame(0, 1'b0, 1, 64'b0, 1'b0, 1'b0);
    ordy_v[0] = 1'b1;
    tick();
    tick();
    d0  = done_cnt0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ordy_v[0] = 1'b0;
    tests++;
    if (cvalid_v[0] !== 1'b0 || busy_v[0] !== 1'b0 || done_v[0] !== 1'b0 || word8 !== 8'h00) begin
      fails++;
      $display("FAIL rst_mid crc_valid=%b busy=%b done=%b word=%h required 0 0 0 00",
               cvalid_v[0], busy_v[0], done_v[0], word8);
    end
    for (int i = 0; i < 10; i++) tick();
    tests++;
    if (done_cnt0 != d0) begin
      fails++;
      $display("FAIL rst_no_done pulses=%0d required 0", done_cnt0 - d0);
    end
    test_gen_single(1'b0, 8'h6C);
  endtask

  task automatic test_w16;
    logic [63:0] bits;
    logic [31:0] exp;
    logic [31:0] c;
    logic [31:0] sb;
    bit          st;
    int          n;
    int          n0;
    bit          mode;
    int          fidx;
    for (int t = 0; t < 200; t++) begin
      mode = ($urandom_range(0, 3) == 0);
      if (!mode) begin
        n = $urandom_range(1, 40);
        bits = {$urandom, $urandom};
        exp = model_crc(32'h8408, 32'hFFFF, n, bits);
        send_frame(1, 1'b0, n, bits, 1'b1, 1'b0);
        collect(1, 16, 1'($urandom_range(0, 1)), 1'b0, sb, st);
        tests++;
        if (sb[15:0] !== exp[15:0] || word16 !== exp[15:0] || !st) begin
          fails++;
          $display("FAIL w16_gen frame=%0d n=%0d serial=%h word=%h stable=%0d required %h",
                   t, n, sb[15:0], word16, st, exp[15:0]);
        end
      end else begin
        n0 = $urandom_range(1, 30);
        bits = {$urandom, $urandom} & ((64'd1 << n0) - 64'd1);
        c = model_crc(32'h8408, 32'hFFFF, n0, bits);
        bits = bits | (64'(c[15:0]) << n0);
        n = n0 + 16;
        if ($urandom_range(0, 1) == 1) begin
          fidx = $urandom_range(0, n - 1);
          bits[fidx] = ~bits[fidx];
        end
        exp = model_crc(32'h8408, 32'hFFFF, n, bits);
        send_frame(1, 1'b1, n, bits, 1'b1, 1'b0);
        tests++;
        if (done_v[1] !== 1'b1 || ok_v[1] !== (exp[15:0] == 16'h0) || word16 !== exp[15:0]) begin
          fails++;
          $display("FAIL w16_check frame=%0d done=%b ok=%b word=%h required 1 %b %h",
                   t, done_v[1], ok_v[1], word16, (exp[15:0] == 16'h0), exp[15:0]);
        end
      end
      tick();
    end
  endtask

  initial begin
    start_v = '0; data_v = '0; dv_v = '0; dl_v = '0; cm_v = '0; ordy_v = '0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    test_reset();
    test_gen_single(1'b0, 8'h6C);
    test_gen_single(1'b1, 8'hA8);
    test_check_mode();
    test_backpressure(1'b0);
    test_reset_mid();
    test_backpressure(1'b1);
    test_w16();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/crc_serial_engine.md
# crc_serial_engine

Parametrised bit-serial CRC engine: the next generation of the fixed 8-bit serial CRC block. It has generic width, polynomial and seed, a framed input handshake, an optional receive-check mode, and a back-pressured serial CRC output. It sits between the UART frame logic and the register/ALU path: it accumulates CRC over a bit stream, then either shifts the CRC out LSB-first or reports a residue check.

## Interface

Parameters:
- WIDTH, 8, CRC register width (2..32)
- TAPS, 7'b1000100, WIDTH-1 bit Galois tap mask; bit i set means fb is XORed into stage i
- SEED, 8'hD8, WIDTH-bit initial register value

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, synchronous and active-high
- start  in  1  load SEED and clear flags; accepted only in IDLE
- data  in  1  serial input bit
- data_valid  in  1  data is consumed in a cycle where data_valid=1 in CALC
- data_last  in  1  qualifies the final bit of the frame; sampled with data_valid
- check_mode  in  1  sampled at start: 0 = generate (shift out CRC), 1 = check residue
- out_ready  in  1  downstream accepts the serial bit this cycle
- crc  out  1  serial CRC bit, LSB first
- crc_valid  out  1  crc holds a valid bit
- crc_word  out  WIDTH  final CRC, held until next start
- crc_ok  out  1  check-mode result, held until next start
- done  out  1  one-cycle pulse at frame completion
- busy  out  1  high in CALC or SHIFT

## Operation

- FSM states are IDLE, CALC and SHIFT. All outputs reset to 0. The register resets to SEED. State resets to IDLE.
- IDLE with start=1 does the following:
  - loads SEED into the register;
  - latches check_mode;
  - clears crc_ok and crc_word;
  - moves to CALC.
- CALC, on each data_valid beat:
  - fb = reg[0] ^ data
  - reg[WIDTH-1] <= fb
  - reg[i] <= reg[i+1] ^ (TAPS[i] & fb) for i < WIDTH-1
  - Cycles with data_valid=0 hold the register.
- CALC with data_valid & data_last: the last bit is folded in the same cycle. The next-state register value is then used as follows.
  - Generate mode: crc_word <= next value; go to SHIFT with bit counter = 0.
  - Check mode: crc_ok <= (next value == 0); crc_word <= next value; done pulses; go to IDLE.
- SHIFT:
  - crc = reg[0] and crc_valid = 1.
  - On out_ready=1: the register shifts right with zero fill and the counter increments.
  - After the WIDTH-th accepted bit: crc_valid drops, done pulses, and the FSM goes to IDLE.
  - out_ready=0 holds crc and the counter.
- start outside IDLE is ignored. data_valid outside CALC is ignored.
- Arithmetic and widths:
  - The counter is $clog2(WIDTH+1) bits and never wraps.
  - crc_word is never modified in SHIFT.

## Timing

- The first CALC beat can occur the cycle after start.
- Generate-mode latency runs from the last-bit beat:
  - crc_valid rises the next cycle.
  - With out_ready held high, all bits are emitted over WIDTH cycles.
  - done is asserted in the cycle after the final accepted bit. crc_valid is 0 in that cycle.
- Check-mode latency: done and crc_ok are valid the cycle after the last-bit beat.
- rst has priority over everything and may arrive mid-CALC or mid-SHIFT. In that case the FSM goes to IDLE, all outputs go to 0, the register goes to SEED, and no done pulse is produced.
- busy = (state != IDLE), registered alongside the state.

## Structure

- Shared package crc_pkg holds:
  - the FSM state encoding (IDLE=2'd0, CALC=2'd1, SHIFT=2'd2);
  - a default-polynomial constant set for WIDTH=8, 16 and 32.
- One natural sub-module is crc_lfsr_step. It is a combinational next-state function of (reg, data, TAPS) and is reused for CALC and for the check-mode compare. The FSM, counter and output registers stay in the top module.

## Test plan

- Defaults, start, single bit data=0 with data_last, out_ready=1 -> crc_word=8'h6C; serial bits 0,0,1,1,0,1,1,0; done pulses 1 cycle after the 8th bit.
- Defaults, single bit data=1 -> crc_word=8'hA8; serial bits 0,0,0,1,0,1,0,1.
- Check mode, frame "0" followed by the 8 bits of 8'h6C LSB-first, last on the 9th bit -> crc_ok=1, crc_word=0. Flipping any one bit -> crc_ok=0.
- Generate mode with out_ready toggled 1,0,0,1,... and gaps in data_valid -> same bit sequence as with a continuous stream; crc is stable while out_ready=0.
- rst asserted on the 3rd SHIFT bit -> next cycle crc_valid=0, busy=0, done=0. A subsequent frame reproduces 8'h6C.
- start asserted during CALC and SHIFT -> ignored, no register reload. WIDTH=16 instance with TAPS=15'h0408 (CRC-16-CCITT reflected) and SEED=16'hFFFF -> checked against a reference model over 200 random frames.
